// File: rtl/weight_bram_sequencer_if.sv
// Signal bundle between weight_bram_sequencer and its surroundings:
// layer-control handshake, load stream, BRAM port and weight stream.
// Optional macro WSEQ_CHECKSUM_EN adds the w_sum checksum signal.
interface weight_bram_sequencer_if #(
   parameter int AW = 5,
   parameter int DW = 16
);
   logic          start;
   logic          mode;
   logic          busy;
   logic          done;
   logic [DW-1:0] ld_data;
   logic          ld_valid;
   logic          ld_ready;
   logic [AW-1:0] bram_addr;
   logic [DW-1:0] bram_di;
   logic          bram_en;
   logic          bram_we;
   logic [DW-1:0] bram_do;
   logic [DW-1:0] w_data;
   logic          w_valid;
   logic          w_last;
   logic          w_ready;
`ifdef WSEQ_CHECKSUM_EN
   logic [DW-1:0] w_sum;
`endif

   // Sequencer view
   modport master (
      input  start, mode, ld_data, ld_valid, bram_do, w_ready,
`ifdef WSEQ_CHECKSUM_EN
      output w_sum,
`endif
      output busy, done, ld_ready, bram_addr, bram_di, bram_en, bram_we,
             w_data, w_valid, w_last
   );

   // Environment view: layer FSM, load source, BRAM and MAC consumer
   modport slave (
      output start, mode, ld_data, ld_valid, bram_do, w_ready,
`ifdef WSEQ_CHECKSUM_EN
      input  w_sum,
`endif
      input  busy, done, ld_ready, bram_addr, bram_di, bram_en, bram_we,
             w_data, w_valid, w_last
   );
endinterface

// File: rtl/weight_bram_sequencer.sv
// weight_bram_sequencer: controller for one negedge-clocked weight BRAM.
//   LOAD   - writes DEPTH words from the ld_* stream to addresses 0..DEPTH-1.
//   STREAM - reads addresses 0..DEPTH-1 and hands them to the MAC over w_*,
//            through a 2-entry FIFO so w_ready may stall on any cycle.
// Optional feature: define WSEQ_CHECKSUM_EN to add the w_sum checksum output.
module weight_bram_sequencer #(
   parameter int DEPTH = 28,
   parameter int AW    = 5,
   parameter int DW    = 16
) (
   input  logic                    CLK,
   input  logic                    RST,
   weight_bram_sequencer_if.master bus
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_STREAM,
      S_DRAIN,
      S_FINISH
   } state_t;

   // Counter is one bit wider than the BRAM address so it can reach DEPTH.
   localparam int          LAST_I    = DEPTH - 1;
   localparam logic [AW:0] LAST_ADDR = LAST_I[AW:0];
   localparam logic [AW:0] END_ADDR  = DEPTH[AW:0];
   localparam logic [AW:0] ADDR_ONE  = {{AW{1'b0}}, 1'b1};

   state_t        r_state;
   state_t        w_state_nxt;
   logic [AW:0]   r_addr;
   logic          r_bram_en;
   logic          r_bram_we;
   logic [AW-1:0] r_bram_addr;
   logic [DW-1:0] r_bram_di;
   logic          r_inflight;
   logic          r_inflight_last;
   logic [DW-1:0] r_fifo_data [2];
   logic          r_fifo_last [2];
   logic          r_rd_ptr;
   logic          r_wr_ptr;
   logic [1:0]    r_count;

   logic          w_start;
   logic          w_start_load;
   logic          w_start_stream;
   logic          w_ld_acc;
   logic          w_pop;
   logic          w_push;
   logic [2:0]    w_occ_after;
   logic          w_room;
   logic [AW:0]   w_issue_addr;
   logic          w_rd_issue;
   logic          w_issue_last;
   logic          w_fifo_nempty;
   logic [DW-1:0] w_head_data;
   logic          w_ld_ready;
   logic          w_busy;
   logic          w_done;

   // Handshakes and the read-issue decision for the current cycle
   always_comb begin
      w_start        = (r_state == S_IDLE) && bus.start;
      w_start_load   = w_start && bus.mode;
      w_start_stream = w_start && !bus.mode;
      w_ld_acc       = (r_state == S_LOAD) && bus.ld_valid;
      w_fifo_nempty  = (r_count != 2'd0);
      w_head_data    = r_fifo_data[r_rd_ptr];
      w_pop          = w_fifo_nempty && bus.w_ready;
      w_push         = r_inflight;
      // Slots still claimed after this cycle's pop; a read may issue only if one is free.
      w_occ_after    = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};
      w_room         = (w_occ_after < 3'd2);
      // The first read goes out on the start cycle itself, from address 0.
      w_issue_addr   = (r_state == S_IDLE) ? '0 : r_addr;
      w_rd_issue     = w_start_stream ||
                       ((r_state == S_STREAM) && (r_addr < END_ADDR) && w_room);
      w_issue_last   = w_rd_issue && (w_issue_addr == LAST_ADDR);
   end

   // Next-state and state-decoded outputs
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
      w_state_nxt = r_state;
      w_ld_ready  = 1'b0;
      w_busy      = 1'b1;
      w_done      = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_busy = 1'b0;
            if (w_start_load) begin
               w_state_nxt = S_LOAD;
            end else if (w_start_stream) begin
               w_state_nxt = w_issue_last ? S_DRAIN : S_STREAM;
            end
         end
         S_LOAD: begin
            w_ld_ready = 1'b1;
            if (w_ld_acc && (r_addr == LAST_ADDR)) begin
               w_state_nxt = S_FINISH;
            end
         end
         S_STREAM: begin
            if (w_issue_last) begin
               w_state_nxt = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (!w_fifo_nempty && !r_inflight) begin
               w_state_nxt = S_FINISH;
            end
         end
         S_FINISH: begin
            w_done      = 1'b1;
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // State register
   always_ff @(posedge CLK) begin
      // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values whatever the block order.
      if (RST) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Address counter and registered BRAM port (sampled by the BRAM on the falling edge)
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_addr      <= '0;
         r_bram_en   <= 1'b0;
         r_bram_we   <= 1'b0;
         r_bram_addr <= '0;
         r_bram_di   <= '0;
      end else begin
         r_bram_en <= 1'b0;
         r_bram_we <= 1'b0;
         if (w_ld_acc) begin
            r_bram_en   <= 1'b1;
            r_bram_we   <= 1'b1;
            r_bram_addr <= r_addr[AW-1:0];
            r_bram_di   <= bus.ld_data;
            r_addr      <= r_addr + ADDR_ONE;
         end else if (w_rd_issue) begin
            r_bram_en   <= 1'b1;
            r_bram_addr <= w_issue_addr[AW-1:0];
            r_addr      <= w_issue_addr + ADDR_ONE;
         end else if (w_start) begin
            r_addr <= '0;
         end
      end
   end

   // In-flight read tracking and FIFO pointers/occupancy
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_inflight      <= 1'b0;
         r_inflight_last <= 1'b0;
         r_rd_ptr        <= 1'b0;
         r_wr_ptr        <= 1'b0;
         r_count         <= 2'd0;
      end else begin
         r_inflight      <= w_rd_issue;
         r_inflight_last <= w_issue_last;
         if (w_push) begin
            r_wr_ptr <= ~r_wr_ptr;
         end
         if (w_pop) begin
            r_rd_ptr <= ~r_rd_ptr;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 2'd1;
            2'b01:   r_count <= r_count - 2'd1;
            default: r_count <= r_count;
         endcase
      end
   end

   // FIFO storage: returning BRAM word plus its last-address tag
   always_ff @(posedge CLK) begin
      // NOTE: storage is deliberately not reset; occupancy is, and the outputs are masked while the FIFO is empty.
      if (w_push) begin
         r_fifo_data[r_wr_ptr] <= bus.bram_do;
         r_fifo_last[r_wr_ptr] <= r_inflight_last;
      end
   end

`ifdef WSEQ_CHECKSUM_EN
   logic [DW-1:0] r_sum;

   // Running modulo-2**DW sum of words written or handed off in this operation
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_sum <= '0;
      end else if (w_start) begin
         r_sum <= '0;
      end else if (w_ld_acc) begin
         r_sum <= r_sum + bus.ld_data;
      end else if (w_pop) begin
         r_sum <= r_sum + w_head_data;
      end
   end

   assign bus.w_sum = r_sum;
`endif

   assign bus.ld_ready  = w_ld_ready;
   assign bus.busy      = w_busy;
   assign bus.done      = w_done;
   assign bus.bram_en   = r_bram_en;
   assign bus.bram_we   = r_bram_we;
   assign bus.bram_addr = r_bram_addr;
   assign bus.bram_di   = r_bram_di;
   assign bus.w_valid   = w_fifo_nempty;
   assign bus.w_data    = w_fifo_nempty ? w_head_data : '0;
   assign bus.w_last    = w_fifo_nempty && r_fifo_last[r_rd_ptr];

endmodule

// File: tb/tb_weight_bram_sequencer.sv
// Testbench for weight_bram_sequencer: behavioural BRAM, queue scoreboard fed at
// start time from a word-array model, and a negedge monitor that pops and compares.
// Define WSEQ_CHECKSUM_EN to also check the w_sum output.
module tb_weight_bram_sequencer;

   localparam int DEPTH = 28;
   localparam int AW    = 5;
   localparam int DW    = 16;

   typedef struct {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } wr_exp_t;

   typedef struct {
      logic [DW-1:0] data;
      logic          last;
   } rd_exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   weight_bram_sequencer_if #(.AW(AW), .DW(DW)) bus ();

   weight_bram_sequencer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
      .CLK (clk),
      .RST (rst),
      .bus (bus.master)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Behavioural BRAM: port sampled on the falling edge, DO valid at the next rising edge
   logic [DW-1:0] bram_mem [2**AW];
   logic [DW-1:0] bram_dout = '0;
   assign bus.bram_do = bram_dout;
   always @(negedge clk) begin
      if (bus.bram_en) begin
         if (bus.bram_we) bram_mem[bus.bram_addr] <= bus.bram_di;
         else             bram_dout <= bram_mem[bus.bram_addr];
      end
   end

   // Reference model: what the BRAM should hold, and the words of the next load
   logic [DW-1:0] model_mem  [DEPTH];
   logic [DW-1:0] load_words [DEPTH];
   wr_exp_t       exp_wr [$];
   rd_exp_t       exp_rd [$];

   int   n_checks = 0;
   int   n_fail   = 0;
   int   done_count, done_cyc, reads_issued, next_rd_addr, taken;
   int   first_valid_cyc, first_take_cyc, last_take_cyc, start_cyc, last_acc_cyc;
   int   ready_mode = 0;
   logic cur_mode = 1'b0;
   logic prev_stall = 1'b0;
   logic [DW-1:0] prev_data = '0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got=0x%0h expected=0x%0h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   task automatic flag(input string name);
      n_checks++;
      n_fail++;
      $display("FAIL %s: got=event expected=none (cycle %0d)", name, cyc);
   endtask

   // Monitor: pops the scoreboard whenever the DUT writes, reads or hands off a word
   always @(negedge clk) begin
      wr_exp_t we;
      rd_exp_t re;
      if (rst) begin
         prev_stall = 1'b0;
      end else begin
         if (bus.bram_en && bus.bram_we) begin
            if (exp_wr.size() == 0) begin
               flag("bram_write_unexpected");
            end else begin
               we = exp_wr.pop_front();
               check("bram_wr_addr", 32'(bus.bram_addr), 32'(we.addr));
               check("bram_wr_di", 32'(bus.bram_di), 32'(we.data));
            end
         end
         if (bus.bram_en && !bus.bram_we) begin
            reads_issued++;
            check("bram_rd_addr", 32'(bus.bram_addr), 32'(next_rd_addr));
            next_rd_addr++;
            check("outstanding_le_2", 32'((reads_issued - taken) <= 2), 32'(1));
         end
         if (prev_stall) begin
            check("stall_w_valid", 32'(bus.w_valid), 32'(1));
            check("stall_w_data", 32'(bus.w_data), 32'(prev_data));
         end
         if (bus.w_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
         if (bus.w_valid && bus.w_ready) begin
            if (exp_rd.size() == 0) begin
               flag("w_word_unexpected");
            end else begin
               re = exp_rd.pop_front();
               check("w_data", 32'(bus.w_data), 32'(re.data));
               check("w_last", 32'(bus.w_last), 32'(re.last));
            end
            if (taken == 0) first_take_cyc = cyc;
            last_take_cyc = cyc;
            taken++;
         end
         prev_stall = bus.w_valid && !bus.w_ready;
         prev_data  = bus.w_data;
         if (bus.done) begin
            done_count++;
            done_cyc = cyc;
         end
      end
   end

   // Consumer: w_ready always high, 1,0,0,1 repeating, or random
   initial begin
      int ph;
      ph = 0;
      bus.w_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         case (ready_mode)
            0:       bus.w_ready = 1'b1;
            1:       bus.w_ready = ((ph % 4) == 0) || ((ph % 4) == 3);
            default: bus.w_ready = 1'($urandom_range(0, 1));
         endcase
         ph++;
      end
   end

   task automatic check_outputs_zero(input string tag);
      check({tag, "_ld_ready"}, 32'(bus.ld_ready), 32'(0));
      check({tag, "_bram_en"}, 32'(bus.bram_en), 32'(0));
      check({tag, "_bram_we"}, 32'(bus.bram_we), 32'(0));
      check({tag, "_bram_addr"}, 32'(bus.bram_addr), 32'(0));
      check({tag, "_bram_di"}, 32'(bus.bram_di), 32'(0));
      check({tag, "_w_valid"}, 32'(bus.w_valid), 32'(0));
      check({tag, "_w_data"}, 32'(bus.w_data), 32'(0));
      check({tag, "_w_last"}, 32'(bus.w_last), 32'(0));
      check({tag, "_busy"}, 32'(bus.busy), 32'(0));
      check({tag, "_done"}, 32'(bus.done), 32'(0));
`ifdef WSEQ_CHECKSUM_EN
      check({tag, "_w_sum"}, 32'(bus.w_sum), 32'(0));
`endif
   endtask

   // Issue a one-cycle start and push the whole expected response for the operation
   task automatic start_op(input logic m);
      @(posedge clk);
      #1;
      done_count = 0;      done_cyc = -1;
      reads_issued = 0;    next_rd_addr = 0;    taken = 0;
      first_valid_cyc = -1; first_take_cyc = -1; last_take_cyc = -1;
      exp_wr.delete();
      exp_rd.delete();
      for (int i = 0; i < DEPTH; i++) begin
         if (m) begin
            exp_wr.push_back('{addr: AW'(i), data: load_words[i]});
            model_mem[i] = load_words[i];
         end else begin
            exp_rd.push_back('{data: model_mem[i], last: (i == DEPTH - 1)});
         end
      end
      bus.start = 1'b1;
      bus.mode  = m;
      cur_mode  = m;
      start_cyc = cyc;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
`ifdef WSEQ_CHECKSUM_EN
      check("w_sum_cleared_on_start", 32'(bus.w_sum), 32'(0));
`endif
   endtask

   // Present load_words in order; optional random ld_valid gaps and a stray start pulse
   task automatic run_load(input bit gaps, input int poke_at);
      int idx;
      int guard;
      idx = 0;
      guard = 0;
      last_acc_cyc = -1;
      while (idx < DEPTH && guard < 500) begin
         bus.ld_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
         bus.ld_data  = bus.ld_valid ? load_words[idx] : DW'($urandom);
         bus.start    = (guard == poke_at);
         bus.mode     = 1'b0;
         @(negedge clk);
         if (bus.ld_valid && bus.ld_ready) begin
            idx++;
            last_acc_cyc = cyc;
         end
         @(posedge clk);
         #1;
         guard++;
      end
      bus.ld_valid = 1'b0;
      bus.start    = 1'b0;
      check("load_all_accepted", 32'(idx), 32'(DEPTH));
   endtask

   // Wait (bounded) for done; optionally pulse start with the other mode mid-operation
   task automatic wait_done(input int budget, input int poke_at);
      int i;
      i = 0;
      while (done_count == 0 && i < budget) begin
         @(posedge clk);
         #1;
         bus.start = (i == poke_at);
         bus.mode  = ~cur_mode;
         i++;
      end
      bus.start = 1'b0;
      check("done_within_budget", 32'(done_count != 0), 32'(1));
   endtask

   task automatic finish_load();
      logic [DW-1:0] s;
      wait_done(100, -1);
      check("load_done_one_cycle_after_last_accept", 32'(done_cyc - last_acc_cyc), 32'(1));
      check("ld_ready_after_done", 32'(bus.ld_ready), 32'(0));
      repeat (3) @(posedge clk);
      #1;
      check("load_done_pulses", 32'(done_count), 32'(1));
      check("load_writes_left", 32'(exp_wr.size()), 32'(0));
      check("busy_after_load", 32'(bus.busy), 32'(0));
      s = '0;
      for (int i = 0; i < DEPTH; i++) s = s + load_words[i];
`ifdef WSEQ_CHECKSUM_EN
      check("w_sum_load", 32'(bus.w_sum), 32'(s));
`endif
   endtask

   task automatic finish_stream(input int poke_at);
      logic [DW-1:0] s;
      wait_done(600, poke_at);
      check("first_w_valid_latency", 32'(first_valid_cyc - start_cyc), 32'(2));
      repeat (3) @(posedge clk);
      #1;
      check("stream_done_pulses", 32'(done_count), 32'(1));
      check("stream_words_taken", 32'(taken), 32'(DEPTH));
      check("stream_words_left", 32'(exp_rd.size()), 32'(0));
      check("stream_reads_issued", 32'(reads_issued), 32'(DEPTH));
      check("busy_after_stream", 32'(bus.busy), 32'(0));
      s = '0;
      for (int i = 0; i < DEPTH; i++) s = s + model_mem[i];
`ifdef WSEQ_CHECKSUM_EN
      check("w_sum_stream", 32'(bus.w_sum), 32'(s));
`endif
   endtask

   initial begin
      int guard;
      bus.start    = 1'b0;
      bus.mode     = 1'b0;
      bus.ld_valid = 1'b0;
      bus.ld_data  = '0;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_outputs_zero("reset");
      rst = 1'b0;

      // LOAD 0x0001..0x001C, ld_valid held high, stray start mid-load
      for (int i = 0; i < DEPTH; i++) load_words[i] = DW'(i + 1);
      start_op(1'b1);
      run_load(1'b0, 5);
      finish_load();

      // STREAM with w_ready held high: one word per cycle
      ready_mode = 0;
      start_op(1'b0);
      finish_stream(-1);
      check("stream_back_to_back", 32'(last_take_cyc - first_take_cyc), 32'(DEPTH - 1));

      // STREAM with w_ready 1,0,0,1 and a stray start
      ready_mode = 1;
      start_op(1'b0);
      finish_stream(8);

      // Random LOAD with ld_valid gaps, then random-backpressure STREAM
      for (int i = 0; i < DEPTH; i++) load_words[i] = DW'($urandom);
      start_op(1'b1);
      run_load(1'b1, 7);
      finish_load();
      ready_mode = 2;
      start_op(1'b0);
      finish_stream(3);

      // Reset in the middle of a stream, then a fresh stream from address 0
      ready_mode = 0;
      start_op(1'b0);
      guard = 0;
      while (taken < 10 && guard < 200) begin
         @(posedge clk);
         #1;
         guard++;
      end
      check("reached_word_10", 32'(taken >= 10), 32'(1));
      rst = 1'b1;
      exp_rd.delete();
      @(posedge clk);
      #1;
      rst = 1'b0;
      check_outputs_zero("mid_reset");
      ready_mode = 2;
      start_op(1'b0);
      finish_stream(-1);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/weight_bram_sequencer.md
Name: weight_bram_sequencer

Overview:
- Controller for one ANN weight BRAM (DEPTH x DW, negedge-clocked, EN/WE, read when WE=0).
- Two modes.
  - LOAD: writes a weight vector into the BRAM from an input stream.
  - STREAM: reads addresses 0..DEPTH-1 in order and presents them to the neuron MAC over a valid/ready stream, with full backpressure support.
- Sits between the layer control FSM and each per-neuron weight BRAM.

Parameters:
- DEPTH, 28, number of weight words (addresses 0..DEPTH-1).
- AW, 5, BRAM address width; DEPTH <= 2**AW.
- DW, 16, weight word width.

Ports:
- CLK  in  1  system clock; all controller logic on rising edge.
- RST  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; sampled only in IDLE.
- mode  in  1  sampled with start: 0 = STREAM, 1 = LOAD.
- ld_data  in  DW  weight word to write.
- ld_valid  in  1  ld_data valid.
- ld_ready  out  1  controller accepts ld_data this cycle.
- bram_addr  out  AW  to BRAM ADDR.
- bram_di  out  DW  to BRAM DI.
- bram_en  out  1  to BRAM EN.
- bram_we  out  1  to BRAM WE.
- bram_do  in  DW  from BRAM DO.
- w_data  out  DW  streamed weight.
- w_valid  out  1  w_data valid.
- w_last  out  1  marks the word from address DEPTH-1.
- w_ready  in  1  consumer accepts w_data.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse when an operation completes.

Behaviour:
- Reset: all outputs 0 (ld_ready, bram_*, w_*, busy, done); FSM goes to IDLE, address counter 0, buffer empty. Reset mid-operation aborts immediately; partial BRAM contents are left as is.
- BRAM timing:
  - bram_* are registered on the rising edge and sampled by the BRAM on the following falling edge.
  - bram_do is valid at the next rising edge, so read latency is 1 CLK from issue.
- States: IDLE, LOAD, STREAM, DRAIN, FINISH.
- IDLE:
  - start=1, mode=1 goes to LOAD; start=1, mode=0 goes to STREAM. Address counter clears to 0.
  - start in any other state is ignored.
- LOAD:
  - ld_ready=1.
  - On ld_valid&&ld_ready, the next cycle drives bram_en=1, bram_we=1, bram_addr=counter, bram_di=ld_data; counter increments.
  - After the write at DEPTH-1 is accepted, go to FINISH; ld_ready drops in that same cycle.
  - ld_valid low leaves bram_en=0 and the counter unchanged.
- STREAM:
  - Uses a 2-entry output FIFO plus an in-flight flag.
  - A read is issued (bram_en=1, bram_we=0, bram_addr=counter, counter++) when occupancy + in_flight − (w_valid&&w_ready) < 2 and counter < DEPTH.
  - Returning data is pushed into the FIFO in the cycle after issue.
  - w_valid = FIFO not empty; w_data = FIFO head; w_last = head tag for address DEPTH-1.
  - After the last issue, go to DRAIN.
  - With w_ready held at 1, sustained throughput is 1 word/cycle; first w_valid appears 2 cycles after start.
- DRAIN: no more issues; go to FINISH when the FIFO is empty and no read is in flight.
- FINISH: done=1 for one cycle, then IDLE.
- Simultaneous push and pop on the FIFO is legal; occupancy stays the same.
- The FIFO never overflows. Words are never dropped or duplicated under any w_ready pattern.
- w_data stays stable while w_valid && !w_ready.
- The counter never exceeds DEPTH; no wrap is possible.
- A DEPTH-word operation always ends with exactly one done pulse.

Optional Feature:
- Macro WSEQ_CHECKSUM_EN adds output port w_sum [DW-1:0].
- w_sum is the modulo-2**DW sum of all words written (LOAD) or handed off via w_valid&&w_ready (STREAM) in the current operation.
- w_sum clears on start and on RST, and holds its value after done until the next start.
- Without the macro, the port and adder are absent and all other behaviour is identical.

Test Plan:
- LOAD of words 0x0001..0x001C with ld_valid held high -> 28 writes to addr 0..27 with matching DI; done pulses 1 cycle after the last write; ld_ready=0 afterwards.
- STREAM with w_ready=1 after that load -> w_data sequence 0x0001..0x001C on consecutive cycles; w_last only on 0x001C; first w_valid 2 cycles after start; exactly one done.
- STREAM with w_ready toggling 1,0,0,1 repeating -> same 28-word sequence with no loss or duplicates; w_data stable while stalled; bram_en never issues a third outstanding read.
- RST asserted at STREAM word 10 -> next cycle all outputs 0 and state IDLE; a new start streams from address 0.
- start pulses during LOAD and STREAM -> ignored; the operation completes unchanged.
- With WSEQ_CHECKSUM_EN, STREAM of the 0x0001..0x001C data -> w_sum = 0x0196 after done; a fresh start clears it to 0.
